// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: counter encoding, BTB entry
// layout and the 2-bit saturating counter update.
package bpu_pkg;

    localparam int DEF_IDX_W = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tag is held zero-extended to 30 bits so the struct does not depend on IDX_W.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    function automatic ctr_t sat_update(ctr_t c, logic taken);
        if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
        else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped BTB storage: async reads for fetch lookup and EX training,
// one synchronous write port at the EX index.
module bpu_table
    import bpu_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] if_idx,
    output btb_entry_t       if_entry,
    input  logic [IDX_W-1:0] ex_idx,
    output btb_entry_t       ex_entry,
    input  logic             we,
    input  btb_entry_t       wdata
);

    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t tbl [ENTRIES];

    // Reads see pre-write state, so a same-cycle lookup never bypasses the update.
    assign if_entry = tbl[if_idx];
    assign ex_entry = tbl[ex_idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= RST_ENTRY;
        end else if (we) begin
            tbl[ex_idx] <= wdata;
        end
    end

endmodule

// File: rtl/bpu_ctrl.sv
// Branch predictor and redirect controller: fetch-time BTB lookup, EX-stage
// mispredict detection with one-cycle redirect/flush, training and statistics.
module bpu_ctrl
    import bpu_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jump,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    btb_entry_t       if_entry, ex_entry, wdata;
    logic             we;
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [29:0]      if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             resolve, act_taken, mispred;
    logic [31:0]      br_cnt, mis_cnt;
    logic             unused_bits;

    assign if_idx = i_if_pc[IDX_W+1:2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign if_tag = 30'(i_if_pc[31:IDX_W+2]);
    assign ex_tag = 30'(i_ex_pc[31:IDX_W+2]);

    bpu_table #(.IDX_W(IDX_W)) u_table (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .if_idx   (if_idx),
        .if_entry (if_entry),
        .ex_idx   (ex_idx),
        .ex_entry (ex_entry),
        .we       (we),
        .wdata    (wdata)
    );

    assign if_hit        = if_entry.valid && (if_entry.tag == if_tag);
    assign o_pred_taken  = if_hit && if_entry.ctr[1];
    assign o_pred_target = o_pred_taken ? if_entry.target : 32'h0;

    assign ex_hit    = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign resolve   = i_rst_n && i_ex_valid && !i_stall && (i_ex_is_br || i_ex_is_jump);
    assign act_taken = i_ex_is_jump || i_ex_taken;
    assign mispred   = resolve && ((act_taken != i_ex_pred_taken) ||
                                   (act_taken && (i_ex_target != i_ex_pred_target)));

    assign o_redirect    = mispred;
    assign o_flush       = mispred;
    assign o_redirect_pc = !mispred  ? 32'h0 :
                           act_taken ? i_ex_target : i_ex_pc + 32'd4;

    // Jumps (including both type bits set) always install strongly taken;
    // a not-taken branch that misses leaves the table alone.
    always_comb begin
        we    = 1'b0;
        wdata = ex_entry;
        if (resolve) begin
            if (i_ex_is_jump) begin
                we    = 1'b1;
                wdata = '{valid: 1'b1, tag: ex_tag, target: i_ex_target, ctr: ST};
            end else if (ex_hit) begin
                we        = 1'b1;
                wdata.ctr = sat_update(ex_entry.ctr, act_taken);
                if (act_taken) wdata.target = i_ex_target;
            end else if (act_taken) begin
                we    = 1'b1;
                wdata = '{valid: 1'b1, tag: ex_tag, target: i_ex_target, ctr: WT};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (resolve) br_cnt  <= br_cnt + 32'd1;
            if (mispred) mis_cnt <= mis_cnt + 32'd1;
        end
    end

    assign o_br_count      = br_cnt;
    assign o_mispred_count = mis_cnt;

    assign unused_bits = ^{i_if_pc[1:0], i_ex_pc[1:0], if_entry.ctr[0]};

endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed self-checking bench for bpu_ctrl: reset, jump/branch training,
// target mismatch, aliasing, stall, counter wrap and reset during redirect.
module tb_bpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall, ex_valid, ex_is_br, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect, flush;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpu_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_stall          (stall),
        .i_ex_valid       (ex_valid),
        .i_ex_is_br       (ex_is_br),
        .i_ex_is_jump     (ex_is_jump),
        .i_ex_pc          (ex_pc),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_target (ex_pred_target),
        .o_redirect       (redirect),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_br_count       (br_count),
        .o_mispred_count  (mispred_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input logic br, input logic jmp, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_br = br; ex_is_jump = jmp; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_redir(input string tag, input logic r, input logic [31:0] pc);
        chk({tag, "_redirect"}, 32'(redirect), 32'(r));
        chk({tag, "_flush"}, 32'(flush), 32'(r));
        chk({tag, "_redirect_pc"}, redirect_pc, pc);
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc,
                            input logic t, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, "_pred_taken"}, 32'(pred_taken), 32'(t));
        chk({tag, "_pred_target"}, pred_target, tgt);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
        chk({tag, "_br_count"}, br_count, b);
        chk({tag, "_mispred_count"}, mispred_count, m);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; if_pc = 32'h100;
        ex_idle(); ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        step(); step();
        // Mispredicting jump during reset must not redirect
        ex_set(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        chk_redir("in_reset", 1'b0, 32'h0);
        step();
        rst_n = 1'b1; ex_idle();
        chk_pred("reset", 32'h100, 1'b0, 32'h0);
        chk_cnt("reset", 32'd0, 32'd0);

        // JAL 0x100 -> 0x200, not predicted
        ex_set(1'b0, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h0);
        #1;
        chk_redir("jal", 1'b1, 32'h200);
        step();
        ex_idle();
        chk_pred("jal_trained", 32'h100, 1'b1, 32'h200);
        chk_cnt("jal", 32'd1, 32'd1);
        chk_redir("jal_bubble", 1'b0, 32'h0);

        // BEQ at 0x40 taken to 0x80, three times
        chk_pred("beq_cold", 32'h40, 1'b0, 32'h0);
        ex_set(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk_redir("beq1", 1'b1, 32'h80);
        step();
        ex_idle();
        chk_pred("beq_alloc", 32'h40, 1'b1, 32'h80);
        chk_pred("alias_0x140", 32'h140, 1'b0, 32'h0);
        ex_set(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk_redir("beq2", 1'b0, 32'h0);
        step();
        #1;
        chk_redir("beq3", 1'b0, 32'h0);
        step();
        // Not taken: ST -> WT, still predicted taken
        ex_set(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk_redir("beq_nt1", 1'b1, 32'h44);
        step();
        ex_idle();
        chk_pred("beq_after_nt1", 32'h40, 1'b1, 32'h80);
        ex_set(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        step();
        ex_idle();
        chk_pred("beq_after_nt2", 32'h40, 1'b0, 32'h0);
        chk_cnt("beq", 32'd6, 32'd4);

        // Target mismatch at 0x180
        ex_set(1'b1, 1'b0, 32'h180, 1'b1, 32'h300, 1'b0, 32'h0);
        step();
        ex_set(1'b1, 1'b0, 32'h180, 1'b1, 32'h304, 1'b1, 32'h300);
        #1;
        chk_redir("tgt_mis", 1'b1, 32'h304);
        step();
        ex_idle();
        chk_pred("tgt_updated", 32'h180, 1'b1, 32'h304);
        chk_cnt("tgt", 32'd8, 32'd6);

        // Stall holds a mispredicting JAL
        stall = 1'b1;
        ex_set(1'b0, 1'b1, 32'h1C0, 1'b1, 32'h400, 1'b0, 32'h0);
        #1;
        chk_redir("stalled", 1'b0, 32'h0);
        step();
        chk_cnt("stalled", 32'd8, 32'd6);
        chk_pred("stalled_no_train", 32'h1C0, 1'b0, 32'h0);
        stall = 1'b0;
        #1;
        chk_redir("unstalled", 1'b1, 32'h400);
        step();
        ex_idle();
        ex_is_jump = 1'b1;  // bubble carrying stale type bits
        #1;
        chk_redir("post_stall_bubble", 1'b0, 32'h0);
        chk_cnt("post_stall", 32'd9, 32'd7);
        ex_idle();

        // Not-taken branch miss: counted, no allocation
        ex_set(1'b1, 1'b0, 32'h200, 1'b0, 32'h600, 1'b0, 32'h0);
        #1;
        chk_redir("nt_miss", 1'b0, 32'h0);
        step();
        ex_idle();
        chk_pred("nt_no_alloc", 32'h200, 1'b0, 32'h0);
        chk_cnt("nt_miss", 32'd10, 32'd7);

        // Counter wrap
        dut.br_cnt = 32'hFFFF_FFFF;
        ex_set(1'b1, 1'b0, 32'h200, 1'b0, 32'h600, 1'b0, 32'h0);
        step();
        ex_idle();
        #1;
        chk_cnt("wrap", 32'd0, 32'd7);

        // Reset asserted while a redirect would fire
        ex_set(1'b0, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk_redir("rst_redirect", 1'b0, 32'h0);
        step();
        rst_n = 1'b1; ex_idle();
        chk_pred("rst_cleared", 32'h100, 1'b0, 32'h0);
        chk_pred("rst_cleared_180", 32'h180, 1'b0, 32'h0);
        chk_cnt("rst_cleared", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
